// File: rtl/parity_pkg.sv
// Shared types and helpers for the even-parity generator / frame transmitter pair.
package parity_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    localparam int unsigned DATA_W_DEF = 4;
    localparam int unsigned FRAME_BITS = DATA_W_DEF + 3;

    // Even parity bit: makes the total number of ones (data + parity) even.
    // Zero-extension to 32 bits leaves the parity unchanged.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and wraps, flagging the last cycle of each bit.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic tick_next
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt + CNT_W'(1);
        if (clear || tick) cnt_next = '0;
    end

    assign tick      = (cnt == LAST);
    // Lets the owner register outputs that must line up with the final cycle of a bit.
    assign tick_next = (cnt_next == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_next;
    end

endmodule

// File: rtl/even_parity_frame_tx.sv
// Serialises a data nibble plus its parity bit as start(0), data LSB-first, parity, stop(1),
// re-checking the parity at acceptance.
module even_parity_frame_tx
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic              par_err
);

    localparam int unsigned IDX_W = $clog2(DATA_W + 1);

    tx_state_t         state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic              par_q, par_q_n;
    logic              par_err_n;
    logic              tx_n, frame_done_n;
    logic              tick, tick_next;
    logic              accept;

    assign accept = in_valid && in_ready;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == IDLE),
        .tick     (tick),
        .tick_next(tick_next)
    );

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        idx_n     = idx;
        par_q_n   = par_q;
        par_err_n = par_err;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n   = START;
                    shreg_n   = in_data;
                    par_q_n   = in_parity;
                    par_err_n = in_parity ^ even_parity(32'(in_data));
                    idx_n     = '0;
                end
            end
            START: if (tick) state_n = DATA;
            DATA: begin
                if (tick) begin
                    shreg_n = shreg >> 1;
                    if (idx == IDX_W'(DATA_W - 1)) begin
                        idx_n   = '0;
                        state_n = PARITY;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            PARITY: if (tick) state_n = STOP;
            STOP:   if (tick) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they stay aligned with the state register.
    always_comb begin
        tx_n = 1'b1;
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
            PARITY:  tx_n = par_q_n;
            default: tx_n = 1'b1;
        endcase
        frame_done_n = (state_n == STOP) && tick_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            idx        <= '0;
            par_q      <= 1'b0;
            par_err    <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            idx        <= idx_n;
            par_q      <= par_q_n;
            par_err    <= par_err_n;
            tx         <= tx_n;
            busy       <= (state_n != IDLE);
            in_ready   <= (state_n == IDLE);
            frame_done <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_even_parity_frame_tx.sv
// Directed bench for even_parity_frame_tx: CLKS_PER_BIT=4 instance plus a CLKS_PER_BIT=1 instance.
module tb_even_parity_frame_tx;
    import parity_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_data;
    logic       in_parity, in_valid;
    logic       in_ready, tx, busy, frame_done, par_err;
    logic [3:0] f_data;
    logic       f_parity, f_valid;
    logic       f_ready, f_tx, f_busy, f_done, f_err;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    even_parity_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(4)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_parity(in_parity), .in_valid(in_valid),
        .in_ready(in_ready), .tx(tx), .busy(busy), .frame_done(frame_done), .par_err(par_err)
    );

    even_parity_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) u_fast (
        .clk(clk), .rst(rst), .in_data(f_data), .in_parity(f_parity), .in_valid(f_valid),
        .in_ready(f_ready), .tx(f_tx), .busy(f_busy), .frame_done(f_done), .par_err(f_err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame on u_dut and samples tx mid-bit. Cycle 1 is the cycle after acceptance.
    // With hold=1, in_valid stays high with changing data; nd/np are left on the bus at the end.
    task automatic run_frame(input logic [3:0] d, input logic p, input logic [6:0] exp,
                             input logic exp_err, input logic hold,
                             input logic [3:0] nd, input logic np, output logic [6:0] got);
        int unsigned w;
        w   = 0;
        got = '0;
        while (!in_ready && w < 100) begin
            step();
            w++;
        end
        chk("ready_wait", {7'b0, in_ready}, 8'd1);
        in_data   = d;
        in_parity = p;
        in_valid  = 1'b1;
        step();
        in_data   = ~d;
        in_parity = ~p;
        if (!hold) in_valid = 1'b0;
        chk("start_tx", {7'b0, tx}, 8'd0);
        chk("par_err", {7'b0, par_err}, {7'b0, exp_err});
        chk("busy", {7'b0, busy}, 8'd1);
        for (int c = 2; c <= 28; c++) begin
            if (hold) begin
                in_data   = (c == 28) ? nd : 4'(c);
                in_parity = np;
            end
            step();
            if (c % 4 == 2) got[6 - (c - 2) / 4] = tx;
            if (hold || c == 14) chk("ready_low", {7'b0, in_ready}, 8'd0);
            if (c == 27) chk("done_early", {7'b0, frame_done}, 8'd0);
            if (c == 28) chk("done_pulse", {7'b0, frame_done}, 8'd1);
        end
        chk("frame_bits", {1'b0, got}, {1'b0, exp});
        step();
        chk("idle_tx", {7'b0, tx}, 8'd1);
        chk("idle_ready", {7'b0, in_ready}, 8'd1);
        chk("done_low", {7'b0, frame_done}, 8'd0);
    endtask

    initial begin
        logic [6:0] got;
        logic [6:0] exp;
        logic [3:0] dv;
        logic       pv;

        rst       = 1'b1;
        in_data   = '0;
        in_parity = 1'b0;
        in_valid  = 1'b0;
        f_data    = '0;
        f_parity  = 1'b0;
        f_valid   = 1'b0;
        step();
        step();
        chk("rst_tx", {7'b0, tx}, 8'd1);
        chk("rst_ready", {7'b0, in_ready}, 8'd1);
        chk("rst_busy", {7'b0, busy}, 8'd0);
        chk("rst_done", {7'b0, frame_done}, 8'd0);
        chk("rst_par_err", {7'b0, par_err}, 8'd0);
        chk("rst_fast_tx", {7'b0, f_tx}, 8'd1);
        rst = 1'b0;
        step();

        // CLKS_PER_BIT=1: 4'b1111 parity 0 -> 0,1,1,1,1,0,1 on consecutive cycles
        f_data   = 4'b1111;
        f_parity = 1'b0;
        f_valid  = 1'b1;
        step();
        f_valid = 1'b0;
        got     = '0;
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) step();
            got[7 - c] = f_tx;
            if (c == 6) chk("fast_done_early", {7'b0, f_done}, 8'd0);
            if (c == 7) chk("fast_done", {7'b0, f_done}, 8'd1);
        end
        chk("fast_bits", {1'b0, got}, {1'b0, 7'b0111101});
        step();
        chk("fast_ready", {7'b0, f_ready}, 8'd1);
        chk("fast_idle_tx", {7'b0, f_tx}, 8'd1);

        // Basic frame
        run_frame(4'b1011, 1'b1, 7'b0110111, 1'b0, 1'b0, 4'b0, 1'b0, got);
        // Bad parity is flagged but sent unchanged; next good frame clears it
        run_frame(4'b0011, 1'b1, 7'b0110011, 1'b1, 1'b0, 4'b0, 1'b0, got);
        chk("err_held", {7'b0, par_err}, 8'd1);
        run_frame(4'b0101, 1'b0, 7'b0101001, 1'b0, 1'b0, 4'b0, 1'b0, got);

        // Busy ignore, then back-to-back with the held request
        run_frame(4'b1000, 1'b1, 7'b0000111, 1'b0, 1'b1, 4'b0111, 1'b1, got);
        run_frame(4'b0111, 1'b1, 7'b0111011, 1'b0, 1'b0, 4'b0, 1'b0, got);

        // Mid-frame async reset during DATA bit 2 (cycles 13..16)
        in_data   = 4'b1011;
        in_parity = 1'b1;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (13) step();
        chk("pre_rst_busy", {7'b0, busy}, 8'd1);
        chk("pre_rst_bit2", {7'b0, tx}, 8'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_tx", {7'b0, tx}, 8'd1);
        chk("async_busy", {7'b0, busy}, 8'd0);
        chk("async_ready", {7'b0, in_ready}, 8'd1);
        step();
        rst = 1'b0;
        step();
        run_frame(4'b0101, 1'b0, 7'b0101001, 1'b0, 1'b0, 4'b0, 1'b0, got);

        // Exhaustive sweep with generator-produced parity and deserialiser check
        for (int d = 0; d < 16; d++) begin
            dv  = 4'(d);
            pv  = even_parity(32'(dv));
            exp = {1'b0, dv[0], dv[1], dv[2], dv[3], pv, 1'b1};
            run_frame(dv, pv, exp, 1'b0, 1'b0, 4'b0, 1'b0, got);
            chk("deser_data", {4'b0, got[2], got[3], got[4], got[5]}, {4'b0, dv});
            chk("deser_even", {7'b0, ^got[5:1]}, 8'd0);
        end
        chk("sweep_par_err", {7'b0, par_err}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
